bcd_scan_display: RTL and testbench

Downstream consumer of the twelve-digit decimal counter. It takes the counter's 48-bit packed BCD digit bus (billions down to ones) and time-multiplexes it onto one seven-segment digit position at a time, along with a digit index, so a small pin budget can drive a scanned multi-digit display. Each frame scans from the most-significant digit to the least. Each frame works on a coherent snapshot, so the counter ticking mid-scan never tears a frame.

---
 rtl/bcd_scan_display.sv | 134 +++++++++++++
 tb/tb_bcd_scan_display.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_scan_display.sv
// Scans a 12-digit packed BCD snapshot onto one seven-segment position per DWELL cycles.
// Optional leading-zero blanking is enabled by defining LZ_BLANK_EN.
module bcd_scan_display #(
  parameter int DWELL = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [47:0] i_digits,
  output logic [6:0]  o_seg,
  output logic        o_dp,
  output logic [3:0]  o_idx,
  output logic        o_frame
);

  typedef enum logic {LOAD, SHOW} state_t;

  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

  state_t      state, state_nx;
  logic [47:0] snap, snap_nx;
  logic [3:0]  idx, idx_nx;
  logic [7:0]  cnt, cnt_nx;
  logic [6:0]  seg_nx;
  logic        dp_nx;
  logic [3:0]  out_idx_nx;
  logic        frame_nx;
  logic [3:0]  cur_digit;
  logic [6:0]  glyph;
  logic        separator;
  logic        blanked;
`ifdef LZ_BLANK_EN
  logic        blank, blank_nx;
`endif

  always_comb begin
    cur_digit = 4'h0;
    for (int d = 0; d < 12; d++) begin
      if (idx == 4'(d)) cur_digit = snap[4*d +: 4];
    end
  end

  // Invalid BCD renders as a dash so a corrupted counter is visible.
  always_comb begin
    case (cur_digit)
      4'd0:    glyph = 7'h3F;
      4'd1:    glyph = 7'h06;
      4'd2:    glyph = 7'h5B;
      4'd3:    glyph = 7'h4F;
      4'd4:    glyph = 7'h66;
      4'd5:    glyph = 7'h6D;
      4'd6:    glyph = 7'h7D;
      4'd7:    glyph = 7'h07;
      4'd8:    glyph = 7'h7F;
      4'd9:    glyph = 7'h6F;
      default: glyph = 7'h40;
    endcase
  end

  assign separator = (idx == 4'd3) || (idx == 4'd6) || (idx == 4'd9);

  always_comb begin
    state_nx   = state;
    snap_nx    = snap;
    idx_nx     = idx;
    cnt_nx     = cnt;
    seg_nx     = 7'h00;
    dp_nx      = 1'b0;
    out_idx_nx = 4'hF;
    frame_nx   = 1'b0;
    blanked    = 1'b0;
`ifdef LZ_BLANK_EN
    blank_nx   = blank;
`endif
    case (state)
      LOAD: begin
        snap_nx  = i_digits;
        idx_nx   = 4'd11;
        cnt_nx   = 8'd0;
        frame_nx = 1'b1;
        state_nx = SHOW;
`ifdef LZ_BLANK_EN
        blank_nx = 1'b1;
`endif
      end
      SHOW: begin
`ifdef LZ_BLANK_EN
        // Flag only survives while every digit so far was zero; ones is never blanked.
        blanked  = blank && (cur_digit == 4'd0) && (idx != 4'd0);
        blank_nx = blank && (cur_digit == 4'd0);
`endif
        out_idx_nx = idx;
        seg_nx     = blanked ? 7'h00 : glyph;
        dp_nx      = !blanked && separator;
        if (cnt == DWELL_LAST) begin
          cnt_nx = 8'd0;
          if (idx == 4'd0) state_nx = LOAD;
          else             idx_nx   = idx - 4'd1;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      default: state_nx = LOAD;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= LOAD;
      snap    <= '0;
      idx     <= 4'd11;
      cnt     <= 8'd0;
      o_seg   <= 7'h00;
      o_dp    <= 1'b0;
      o_idx   <= 4'hF;
      o_frame <= 1'b0;
`ifdef LZ_BLANK_EN
      blank   <= 1'b1;
`endif
    end else begin
      state   <= state_nx;
      snap    <= snap_nx;
      idx     <= idx_nx;
      cnt     <= cnt_nx;
      o_seg   <= seg_nx;
      o_dp    <= dp_nx;
      o_idx   <= out_idx_nx;
      o_frame <= frame_nx;
`ifdef LZ_BLANK_EN
      blank   <= blank_nx;
`endif
    end
  end

endmodule

// File: tb/tb_bcd_scan_display.sv
// Directed self-checking bench for bcd_scan_display with DWELL=2.
// Expectations follow LZ_BLANK_EN when it is defined for the build.
module tb_bcd_scan_display;

  localparam int DW = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [47:0] digits;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  idx;
  logic        frame;

  int tests_run = 0;
  int tests_failed = 0;

  bcd_scan_display #(.DWELL(DW)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_digits(digits),
    .o_seg   (seg),
    .o_dp    (dp),
    .o_idx   (idx),
    .o_frame (frame)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered while the LOAD cycle of a frame is on the outputs; returns on the next LOAD cycle.
  task automatic check_frame(input logic [47:0] snap, input int change_at,
                             input logic [47:0] new_digits, input string name);
    logic       lz = 1'b1;
    logic       exp_blank = 1'b0;
    logic [3:0] d;
    logic [6:0] exp_seg;
    logic       exp_dp;
    int         di;
    for (int k = 0; k < 12*DW; k++) begin
      if (k == change_at) digits = new_digits;
      step();
      di = 11 - k/DW;
      d  = snap[di*4 +: 4];
      if (k % DW == 0) begin
`ifdef LZ_BLANK_EN
        exp_blank = lz && (d == 4'd0) && (di != 0);
`else
        exp_blank = 1'b0;
`endif
        lz = lz && (d == 4'd0);
      end
      exp_seg = exp_blank ? 7'h00 : glyph_of(d);
      exp_dp  = !exp_blank && (di == 3 || di == 6 || di == 9);
      tests_run++;
      if (idx !== 4'(di)) begin
        tests_failed++;
        $display("[TB] FAIL %s idx cycle %0d: got %0d expected %0d", name, k, idx, di);
      end
      tests_run++;
      if (seg !== exp_seg) begin
        tests_failed++;
        $display("[TB] FAIL %s seg idx %0d: got %h expected %h", name, di, seg, exp_seg);
      end
      tests_run++;
      if (dp !== exp_dp) begin
        tests_failed++;
        $display("[TB] FAIL %s dp idx %0d: got %b expected %b", name, di, dp, exp_dp);
      end
      tests_run++;
      if (frame !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL %s frame idx %0d: got %b expected 0", name, di, frame);
      end
    end
    step();
    tests_run++;
    if (frame !== 1'b1 || idx !== 4'hF || seg !== 7'h00 || dp !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL %s next load: frame=%b idx=%0d seg=%h dp=%b expected 1/15/00/0",
               name, frame, idx, seg, dp);
    end
  endtask

  task automatic start_frame(input logic [47:0] value);
    int n = 0;
    digits = value;
    do begin
      step();
      n++;
    end while (frame !== 1'b1 && n < 60);
    tests_run++;
    if (frame !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL frame_wait: got frame=%b expected 1 within 60 cycles", frame);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    digits = 48'h0;
    step();
    step();
    tests_run++;
    if (seg !== 7'h00 || dp !== 1'b0 || idx !== 4'hF || frame !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_values: seg=%h dp=%b idx=%0d frame=%b expected 00/0/15/0",
               seg, dp, idx, frame);
    end
    rst = 1'b0;
    step();
    tests_run++;
    if (frame !== 1'b1 || idx !== 4'hF || seg !== 7'h00 || dp !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL first_load: frame=%b idx=%0d seg=%h dp=%b expected 1/15/00/0",
               frame, idx, seg, dp);
    end
    check_frame(48'h0, -1, 48'h0, "zeros");
  endtask

  task automatic test_leading_zeros();
    start_frame(48'h000000001234);
    check_frame(48'h000000001234, -1, 48'h0, "lz_1234");
  endtask

  task automatic test_inner_zeros();
    start_frame(48'h000000100000);
    check_frame(48'h000000100000, -1, 48'h0, "inner_zeros");
  endtask

  task automatic test_midframe_change();
    start_frame(48'h1);
    check_frame(48'h1, 7, 48'h9, "mid_change_old");
    check_frame(48'h9, -1, 48'h0, "mid_change_new");
  endtask

  task automatic test_invalid_bcd();
    start_frame(48'hB00000000000);
    check_frame(48'hB00000000000, -1, 48'h0, "invalid_bcd");
  endtask

  task automatic test_reset_midframe();
    int n = 0;
    start_frame(48'h987654321098);
    while (idx !== 4'd6 && n < 40) begin
      step();
      n++;
    end
    tests_run++;
    if (idx !== 4'd6) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_wait: got idx=%0d expected 6", idx);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests_run++;
    if (seg !== 7'h00 || dp !== 1'b0 || idx !== 4'hF || frame !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_values: seg=%h dp=%b idx=%0d frame=%b expected 00/0/15/0",
               seg, dp, idx, frame);
    end
    step();
    tests_run++;
    if (frame !== 1'b1 || idx !== 4'hF) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_load: frame=%b idx=%0d expected 1/15", frame, idx);
    end
    check_frame(48'h987654321098, -1, 48'h0, "after_reset");
  endtask

  initial begin
    rst = 1'b1;
    digits = 48'h0;
    test_reset();
    test_leading_zeros();
    test_inner_zeros();
    test_midframe_change();
    test_invalid_bcd();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
